// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART TX arbiter: FSM state encoding,
// parameter defaults and the round-robin successor helper.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_t;

  localparam int N_REQ_DEF         = 4;
  localparam int DATA_W_DEF        = 8;
  localparam int START_TIMEOUT_DEF = 16;

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational find-first-set over req_valid starting at ptr, wrapping modulo N_REQ.
// Zero latency; no flow control of its own.
module rr_picker #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     found,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int PW = $clog2(N_REQ);

  // Walk from the farthest offset back to ptr so the closest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[PW'((int'(ptr) + k) % N_REQ)]) begin
        found = 1'b1;
        idx   = PW'((int'(ptr) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART TX among N_REQ byte sources; grant one edge after valid in IDLE.
// Backpressure: a source holds its byte until its one-cycle req_ready; no grant while uart_busy is high.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ         = N_REQ_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      uart_start,
  output logic [DATA_W-1:0]         uart_data,
  input  logic                      uart_busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      active,
  output logic                      tx_done,
  output logic                      timeout_err
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(START_TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);

  arb_state_t          state_q;
  logic [PW-1:0]       ptr_q;
  logic [CW-1:0]       cnt_q;

  logic                pick_found;
  logic [PW-1:0]       pick_idx;
  logic [DATA_W-1:0]   pick_dat;
  logic [N_REQ-1:0]    pick_oh;
  logic [PW-1:0]       ptr_after_grant;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .found     (pick_found),
    .idx       (pick_idx)
  );

  always_comb begin
    pick_dat = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == PW'(i)) pick_dat = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign pick_oh         = N_REQ'(1) << pick_idx;
  assign ptr_after_grant = PW'(next_idx(int'(grant_id), N_REQ));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      req_ready   <= '0;
      uart_start  <= 1'b0;
      uart_data   <= '0;
      grant_id    <= '0;
      active      <= 1'b0;
      tx_done     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      req_ready   <= '0;
      tx_done     <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // A frame left over from before reset must finish before we start another.
          if (pick_found && !uart_busy) begin
            req_ready  <= pick_oh;
            uart_data  <= pick_dat;
            grant_id   <= pick_idx;
            uart_start <= 1'b1;
            active     <= 1'b1;
            cnt_q      <= '0;
            state_q    <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          cnt_q <= cnt_q + CW'(1);
          if (uart_busy) begin
            uart_start <= 1'b0;
            state_q    <= ST_WAIT_DONE;
          end else if (cnt_q == CNT_LAST) begin
            // The acknowledged byte is lost; the requester also forfeits its turn.
            uart_start  <= 1'b0;
            active      <= 1'b0;
            timeout_err <= 1'b1;
            ptr_q       <= ptr_after_grant;
            state_q     <= ST_IDLE;
          end
        end
        ST_WAIT_DONE: begin
          if (!uart_busy) begin
            tx_done <= 1'b1;
            active  <= 1'b0;
            ptr_q   <= ptr_after_grant;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: requester drivers and a UART busy model feed the DUT,
// a monitor compares every cycle against a round-robin reference model and byte scoreboard.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int ST = 16;
  localparam int BM_NORMAL = 0;
  localparam int BM_DEAD   = 1;
  localparam int BM_FORCE  = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [N-1:0]       req_valid;
  logic [N*W-1:0]     req_data;
  logic [N-1:0]       req_ready;
  logic               uart_start;
  logic [W-1:0]       uart_data;
  logic               uart_busy;
  logic [1:0]         grant_id;
  logic               active;
  logic               tx_done;
  logic               timeout_err;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .START_TIMEOUT(ST)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .uart_start  (uart_start),
    .uart_data   (uart_data),
    .uart_busy   (uart_busy),
    .grant_id    (grant_id),
    .active      (active),
    .tx_done     (tx_done),
    .timeout_err (timeout_err)
  );

  initial forever #5 clk = ~clk;

  // Requester side: bytes waiting to be offered, and bytes offered but not yet granted.
  logic [W-1:0] pend_q [N][$];
  logic [W-1:0] exp_q  [N][$];
  logic [N-1:0] offering;
  logic [W-1:0] cur_dat [N];
  int           offer_pct;

  // UART busy model controls.
  int   bm_mode, rise_dly, frame_len;
  logic force_val;

  // Reference model and event logs.
  int          ph, mptr, win, gcyc, cyc;
  logic [W-1:0] exp_dat;
  int          grants[$];
  int          gaps[$];
  int          to_lat[$];
  int          done_cnt, to_cnt;
  int          fall_cyc, start_cyc;
  logic        prev_busy, prev_start;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  function automatic bit all_idle();
    for (int i = 0; i < N; i++) begin
      if (pend_q[i].size() != 0 || offering[i]) return 1'b0;
    end
    return (ph == 0) && !uart_busy;
  endfunction

  task automatic drive_loop();
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (offering[i] && req_ready[i]) offering[i] = 1'b0;
        if (!offering[i] && pend_q[i].size() > 0 && int'($urandom_range(99)) < offer_pct) begin
          cur_dat[i] = pend_q[i].pop_front();
          exp_q[i].push_back(cur_dat[i]);
          offering[i] = 1'b1;
        end
        req_valid[i] = offering[i];
        req_data[i*W +: W] = offering[i] ? cur_dat[i] : W'($urandom);
      end
    end
  endtask

  task automatic busy_loop();
    int rw = 0;
    int hold = 0;
    forever begin
      @(negedge clk);
      if (bm_mode == BM_DEAD) begin
        uart_busy = 1'b0; rw = 0; hold = 0;
      end else if (bm_mode == BM_FORCE) begin
        uart_busy = force_val; rw = 0; hold = 0;
      end else if (rw > 0) begin
        rw--;
        if (rw == 0) begin uart_busy = 1'b1; hold = frame_len; end
      end else if (uart_busy) begin
        if (hold <= 1) uart_busy = 1'b0;
        else hold--;
      end else if (uart_start) begin
        rw = rise_dly;
      end
    end
  endtask

  task automatic mon_loop();
    logic [N-1:0] exp_rdy;
    logic         exp_done, exp_to;
    int           w;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!reset) begin
        ph = 0; mptr = 0; win = 0; exp_dat = '0;
        chk("reset_outputs", {req_ready, uart_start, uart_data, grant_id, active, tx_done, timeout_err}, 64'd0);
      end else begin
        exp_rdy = '0; exp_done = 1'b0; exp_to = 1'b0;
        if (prev_busy && !uart_busy) fall_cyc = cyc;
        if (!prev_start && uart_start) start_cyc = cyc;
        if (ph == 0) begin
          if (|req_valid && !uart_busy) begin
            w = rr_pick(req_valid, mptr);
            exp_rdy[w] = 1'b1;
            win = w; gcyc = cyc; ph = 1;
            grants.push_back(w);
            gaps.push_back(cyc - fall_cyc + 1);
            chk("scoreboard_has_byte", exp_q[w].size() > 0, 1);
            if (exp_q[w].size() > 0) exp_dat = exp_q[w].pop_front();
          end
        end else if (ph == 1) begin
          if (uart_busy) ph = 2;
          else if (cyc - gcyc == ST) begin
            exp_to = 1'b1; mptr = (win + 1) % N; ph = 0;
          end
        end else begin
          if (!uart_busy) begin
            exp_done = 1'b1; mptr = (win + 1) % N; ph = 0;
          end
        end
        if (tx_done) done_cnt++;
        if (timeout_err) begin
          to_cnt++;
          to_lat.push_back(cyc - start_cyc);
        end
        chk("req_ready", req_ready, exp_rdy);
        chk("tx_done", tx_done, exp_done);
        chk("timeout_err", timeout_err, exp_to);
        chk("active", active, ph != 0);
        chk("uart_start", uart_start, ph == 1);
        chk("grant_id", grant_id, win);
        chk("uart_data", uart_data, exp_dat);
      end
      prev_busy  = uart_busy;
      prev_start = uart_start;
    end
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int n = 0;
    while (n < budget && !all_idle()) begin
      @(negedge clk);
      n++;
    end
    chk(name, n < budget, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_grants(input int cnt, input int budget);
    int n = 0;
    while (n < budget && grants.size() < cnt) begin
      @(negedge clk);
      n++;
    end
    chk("grant_within_budget", n < budget, 1);
  endtask

  task automatic pulse_reset_check();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_immediate", {req_ready, uart_start, uart_data, grant_id, active, tx_done, timeout_err}, 64'd0);
  endtask

  initial begin
    int n;
    int d0;
    int t0;
    int cnt;
    int exp_order[$];
    reset = 1'b1; req_valid = '0; req_data = '0; uart_busy = 1'b0; offering = '0;
    offer_pct = 100; bm_mode = BM_NORMAL; rise_dly = 2; frame_len = 11; force_val = 1'b0;
    ph = 0; mptr = 0; win = 0; gcyc = 0; cyc = 0; exp_dat = '0;
    done_cnt = 0; to_cnt = 0; fall_cyc = 0; start_cyc = 0; prev_busy = 1'b0; prev_start = 1'b0;
    fork
      drive_loop();
      busy_loop();
      mon_loop();
    join_none
    #2 reset = 1'b0;
    #1 chk("reset_initial", {req_ready, uart_start, uart_data, grant_id, active, tx_done, timeout_err}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Single requester.
    grants.delete(); d0 = done_cnt;
    pend_q[1].push_back(8'hA5);
    wait_quiet("single_quiet", 100);
    chk("single_grant_count", grants.size(), 1);
    if (grants.size() >= 1) chk("single_grant_idx", grants[0], 1);
    chk("single_tx_done_count", done_cnt - d0, 1);
    chk("single_data_held", uart_data, 8'hA5);
    chk("single_grant_id_held", grant_id, 1);

    // All four at once, straight out of reset.
    pulse_reset_check();
    for (int i = 0; i < N; i++) pend_q[i].push_back(W'(8'h10 + i));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    grants.delete(); gaps.delete();
    wait_quiet("simul_quiet", 300);
    chk("simul_grant_count", grants.size(), 4);
    for (int i = 0; i < N; i++) if (i < grants.size()) chk("simul_order", grants[i], i);
    for (int i = 1; i < 4; i++) if (i < gaps.size()) chk("simul_gap_after_busy_fall", gaps[i], 2);

    // Wrap and fairness.
    grants.delete();
    for (int k = 0; k < 3; k++) pend_q[3].push_back(W'(8'h30 + k));
    wait_grants(1, 60);
    for (int k = 0; k < 2; k++) pend_q[0].push_back(W'(8'h40 + k));
    wait_quiet("wrap_quiet", 400);
    exp_order = '{3, 0, 3, 0, 3};
    chk("wrap_grant_count", grants.size(), 5);
    for (int i = 0; i < 5; i++) if (i < grants.size()) chk("wrap_order", grants[i], exp_order[i]);

    // Start timeout: busy never rises.
    bm_mode = BM_DEAD;
    grants.delete(); to_lat.delete(); t0 = to_cnt;
    pend_q[2].push_back(8'h7E);
    wait_grants(1, 50);
    pend_q[2].push_back(8'h7F);
    pend_q[3].push_back(8'h33);
    wait_quiet("timeout_quiet", 200);
    chk("timeout_count", to_cnt - t0, 3);
    exp_order = '{2, 3, 2};
    chk("timeout_grant_count", grants.size(), 3);
    for (int i = 0; i < 3; i++) if (i < grants.size()) chk("timeout_order", grants[i], exp_order[i]);
    for (int i = 0; i < to_lat.size(); i++) chk("timeout_latency", to_lat[i], ST);

    // Reset while a frame is in flight.
    bm_mode = BM_NORMAL; rise_dly = 2; frame_len = 12;
    grants.delete();
    pend_q[0].push_back(8'hC3);
    n = 0;
    while (n < 50 && !(uart_busy && active)) begin @(negedge clk); n++; end
    chk("midrst_reached_wait_done", n < 50, 1);
    bm_mode = BM_FORCE; force_val = 1'b1;
    pulse_reset_check();
    pend_q[0].push_back(8'hC4);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_no_grant_while_busy", grants.size(), 1);
    bm_mode = BM_NORMAL;
    wait_quiet("midrst_quiet", 100);
    chk("midrst_grant_count", grants.size(), 2);
    if (grants.size() >= 2) chk("midrst_regrant_idx", grants[1], 0);

    // Busy already high when the request arrives.
    bm_mode = BM_FORCE; force_val = 1'b1;
    repeat (2) @(negedge clk);
    grants.delete();
    pend_q[0].push_back(8'h5A);
    repeat (8) @(negedge clk);
    chk("busyhigh_no_grant", grants.size(), 0);
    bm_mode = BM_NORMAL;
    wait_quiet("busyhigh_quiet", 100);
    chk("busyhigh_grant_count", grants.size(), 1);

    // Randomized traffic.
    for (int r = 0; r < 5; r++) begin
      bm_mode   = (r == 2) ? BM_DEAD : BM_NORMAL;
      rise_dly  = int'($urandom_range(6, 1));
      frame_len = int'($urandom_range(12, 3));
      offer_pct = int'($urandom_range(100, 30));
      for (int i = 0; i < N; i++) begin
        cnt = int'($urandom_range(5, 2));
        for (int k = 0; k < cnt; k++) pend_q[i].push_back(W'($urandom));
      end
      wait_quiet("random_quiet", 2500);
    end
    for (int i = 0; i < N; i++) chk("scoreboard_drained", exp_q[i].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
